// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stalls, flushes, data-access mask and halt FSM.
// Optional perf counters (stall_cnt, flush_cnt) enabled by HAZARD_PERF_EN.
module hazard_ctrl #(
  parameter int REGW = 5
`ifdef HAZARD_PERF_EN
  , parameter int CNTW = 32
`endif
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            memcuDRE,
  input  logic            memcuDWE,
  input  logic            membrnch_eq,
  input  logic            membrnch_ne,
  input  logic            memZero,
  input  logic            excuDRE,
  input  logic [REGW-1:0] exwsel,
  input  logic [REGW-1:0] idrsel1,
  input  logic [REGW-1:0] idrsel2,
  input  logic            id_uses_rt,
  input  logic            idJALflag,
  input  logic            wbhalt,
  output logic            pc_en,
  output logic            ifW,
  output logic            idW,
  output logic            exW,
  output logic            memW,
  output logic            ifnRST,
  output logic            idnRST,
  output logic            exnRST,
  output logic            memnRST,
  output logic            dmask,
  output logic            halted
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN,
    DDONE,
    HALT
  } state_t;

  state_t state, stateNext;

  logic memreq, ddone, freeze;
  logic btaken, luse, rtHit;

  assign memreq = memcuDRE | memcuDWE;
  assign ddone  = dhit | (state == DDONE);
  assign freeze = ~ihit | (memreq & ~ddone);
  assign btaken = (membrnch_eq & memZero)
                | (membrnch_ne & ~memZero);
  assign rtHit  = id_uses_rt & (exwsel == idrsel2);
  assign luse   = excuDRE & (exwsel != '0)
                & ((exwsel == idrsel1) | rtHit);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      RUN: begin
        if (wbhalt & ~freeze)
          stateNext = HALT;
        else if (memreq & dhit & ~ihit)
          stateNext = DDONE;
      end
      DDONE: begin
        if (wbhalt & ~freeze)
          stateNext = HALT;
        else if (~freeze)
          stateNext = RUN;
      end
      HALT:    stateNext = HALT;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    pc_en   = 1'b0;
    ifW     = 1'b0;
    idW     = 1'b0;
    exW     = 1'b0;
    memW    = 1'b0;
    ifnRST  = 1'b1;
    idnRST  = 1'b1;
    exnRST  = 1'b1;
    memnRST = 1'b1;
    dmask   = 1'b0;
    halted  = 1'b0;
    if (!nRST) begin
      halted = 1'b0;
    end else if (state == HALT) begin
      dmask  = 1'b1;
      halted = 1'b1;
    end else if (freeze) begin
      // completed access must not be reissued while held
      dmask = (state == DDONE);
    end else if (btaken) begin
      {pc_en, ifW, idW, exW, memW} = 5'b11111;
      ifnRST = 1'b0;
      idnRST = 1'b0;
      exnRST = 1'b0;
    end else if (luse) begin
      idW    = 1'b1;
      idnRST = 1'b0;
      exW    = 1'b1;
      memW   = 1'b1;
    end else begin
      {pc_en, ifW, idW, exW, memW} = 5'b11111;
      ifnRST = ~idJALflag;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (state != HALT) begin
      if (freeze | luse)
        stall_cnt <= stall_cnt + 1'b1;
      if (~freeze & (btaken | idJALflag))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl against a rule-level model.
// Build with HAZARD_PERF_EN to also check the perf counters.
module tb_hazard_ctrl;

  localparam int REGW = 5;

  logic CLK = 1'b0;
  logic nRST, ihit, dhit;
  logic memcuDRE, memcuDWE;
  logic membrnch_eq, membrnch_ne, memZero;
  logic excuDRE, id_uses_rt, idJALflag, wbhalt;
  logic [REGW-1:0] exwsel, idrsel1, idrsel2;
  logic pc_en, ifW, idW, exW, memW;
  logic ifnRST, idnRST, exnRST, memnRST;
  logic dmask, halted;

`ifdef HAZARD_PERF_EN
  localparam int CNTW = 4;
  logic [CNTW-1:0] stall_cnt, flush_cnt;
  int unsigned mStall, mFlush;
`endif

  int vecs = 0;
  int miss = 0;
  bit mHalt, mPend;
  logic [10:0] obs, want;

  always #5 CLK = ~CLK;

  assign obs = {pc_en, ifW, idW, exW, memW,
                ifnRST, idnRST, exnRST, memnRST,
                dmask, halted};

  hazard_ctrl #(
    .REGW(REGW)
`ifdef HAZARD_PERF_EN
    , .CNTW(CNTW)
`endif
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ihit(ihit),
    .dhit(dhit),
    .memcuDRE(memcuDRE),
    .memcuDWE(memcuDWE),
    .membrnch_eq(membrnch_eq),
    .membrnch_ne(membrnch_ne),
    .memZero(memZero),
    .excuDRE(excuDRE),
    .exwsel(exwsel),
    .idrsel1(idrsel1),
    .idrsel2(idrsel2),
    .id_uses_rt(id_uses_rt),
    .idJALflag(idJALflag),
    .wbhalt(wbhalt),
    .pc_en(pc_en),
    .ifW(ifW),
    .idW(idW),
    .exW(exW),
    .memW(memW),
    .ifnRST(ifnRST),
    .idnRST(idnRST),
    .exnRST(exnRST),
    .memnRST(memnRST),
    .dmask(dmask),
    .halted(halted)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  function automatic bit frozen();
    bit req;
    req = memcuDRE || memcuDWE;
    return !ihit || (req && !(dhit || mPend));
  endfunction

  function automatic bit taken();
    return (membrnch_eq && memZero)
        || (membrnch_ne && !memZero);
  endfunction

  function automatic bit loadUse();
    bit srcHit;
    srcHit = (exwsel == idrsel1)
          || (id_uses_rt && exwsel == idrsel2);
    return excuDRE && exwsel != 0 && srcHit;
  endfunction

  // {pc_en, W x4, flush x4, dmask, halted}
  function automatic logic [10:0] model();
    if (!nRST)   return 11'b0_0000_1111_0_0;
    if (mHalt)   return 11'b0_0000_1111_1_1;
    if (frozen())
      return {5'b00000, 4'b1111, mPend, 1'b0};
    if (taken())   return 11'b1_1111_0001_0_0;
    if (loadUse()) return 11'b0_0111_1011_0_0;
    if (idJALflag) return 11'b1_1111_0111_0_0;
    return 11'b1_1111_1111_0_0;
  endfunction

  task automatic idle();
    ihit        = 1'b1;
    dhit        = 1'b0;
    memcuDRE    = 1'b0;
    memcuDWE    = 1'b0;
    membrnch_eq = 1'b0;
    membrnch_ne = 1'b0;
    memZero     = 1'b0;
    excuDRE     = 1'b0;
    exwsel      = '0;
    idrsel1     = '0;
    idrsel2     = '0;
    id_uses_rt  = 1'b0;
    idJALflag   = 1'b0;
    wbhalt      = 1'b0;
  endtask

  task automatic settle();
    @(negedge CLK);
  endtask

  // advance the model by one clock, then the DUT
  task automatic tick();
    bit req;
    req = memcuDRE || memcuDWE;
    if (!nRST) begin
      mHalt = 0;
      mPend = 0;
`ifdef HAZARD_PERF_EN
      mStall = 0;
      mFlush = 0;
`endif
    end else if (!mHalt) begin
`ifdef HAZARD_PERF_EN
      if (frozen() || loadUse()) mStall++;
      if (!frozen() && (taken() || idJALflag)) mFlush++;
`endif
      if (wbhalt && !frozen()) begin
        mHalt = 1;
        mPend = 0;
      end else begin
        mPend = frozen() && (mPend || (req && dhit));
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    idle();
    settle();
    want = model();
    vecs++;
    if (obs !== want) begin
      miss++;
      $display("FAIL reset_hold: got %b want %b", obs, want);
    end
    excuDRE = 1'b1; exwsel = 5'd3; idrsel1 = 5'd3;
    wbhalt = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want) begin
      miss++;
      $display("FAIL reset_hazin: got %b want %b", obs, want);
    end
    tick();
    nRST = 1'b1;
    idle();
    settle();
    want = model();
    vecs++;
    if (obs !== 11'b1_1111_1111_0_0 || obs !== want) begin
      miss++;
      $display("FAIL reset_release: got %b want %b", obs, want);
    end
    tick();
  endtask

  task automatic test_load_use();
    idle();
    excuDRE = 1'b1; exwsel = 5'd8;
    idrsel1 = 5'd2; idrsel2 = 5'd8; id_uses_rt = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || pc_en !== 1'b0) begin
      miss++;
      $display("FAIL luse_stall: got %b want %b", obs, want);
    end
    tick();
    excuDRE = 1'b0;
    memcuDRE = 1'b1; dhit = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || pc_en !== 1'b1) begin
      miss++;
      $display("FAIL luse_after: got %b want %b", obs, want);
    end
    tick();
    idle();
    excuDRE = 1'b1; exwsel = 5'd0;
    idrsel1 = 5'd0; idrsel2 = 5'd0; id_uses_rt = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || pc_en !== 1'b1) begin
      miss++;
      $display("FAIL luse_r0: got %b want %b", obs, want);
    end
    tick();
  endtask

  task automatic test_dwait();
    idle();
    memcuDRE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      want = model();
      vecs++;
      if (obs !== want || obs[10:6] !== 5'b0) begin
        miss++;
        $display("FAIL dwait_%0d: got %b want %b", i, obs, want);
      end
      tick();
    end
    dhit = 1'b1; ihit = 1'b0;
    settle();
    want = model();
    vecs++;
    if (obs !== want) begin
      miss++;
      $display("FAIL dwait_dhit: got %b want %b", obs, want);
    end
    tick();
    dhit = 1'b0;
    for (int i = 0; i < 2; i++) begin
      settle();
      want = model();
      vecs++;
      if (obs !== want || dmask !== 1'b1) begin
        miss++;
        $display("FAIL ddone_%0d: got %b want %b", i, obs, want);
      end
      tick();
    end
    ihit = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || pc_en !== 1'b1) begin
      miss++;
      $display("FAIL ddone_adv: got %b want %b", obs, want);
    end
    tick();
    memcuDRE = 1'b0;
    settle();
    want = model();
    vecs++;
    if (obs !== want || dmask !== 1'b0) begin
      miss++;
      $display("FAIL ddone_exit: got %b want %b", obs, want);
    end
    tick();
  endtask

  task automatic test_branch();
    idle();
    membrnch_ne = 1'b1; memZero = 1'b0;
    excuDRE = 1'b1; exwsel = 5'd4; idrsel1 = 5'd4;
    idJALflag = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || obs !== 11'b1_1111_0001_0_0) begin
      miss++;
      $display("FAIL branch_pri: got %b want %b", obs, want);
    end
    tick();
    idle();
    membrnch_eq = 1'b1; memZero = 1'b0;
    idJALflag = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want) begin
      miss++;
      $display("FAIL jal_only: got %b want %b", obs, want);
    end
    tick();
  endtask

  task automatic test_halt();
    idle();
    wbhalt = 1'b1; ihit = 1'b0;
    settle();
    want = model();
    vecs++;
    if (obs !== want || halted !== 1'b0) begin
      miss++;
      $display("FAIL halt_frozen: got %b want %b", obs, want);
    end
    tick();
    ihit = 1'b1;
    tick();
    wbhalt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      membrnch_ne = 1'(i);
      settle();
      want = model();
      vecs++;
      if (obs !== want || halted !== 1'b1) begin
        miss++;
        $display("FAIL halt_%0d: got %b want %b", i, obs, want);
      end
      tick();
    end
    idle();
    nRST = 1'b0;
    settle();
    want = model();
    vecs++;
    if (obs !== want || halted !== 1'b0) begin
      miss++;
      $display("FAIL halt_async: got %b want %b", obs, want);
    end
    tick();
    nRST = 1'b1;
    settle();
    want = model();
    vecs++;
    if (obs !== want || halted !== 1'b0) begin
      miss++;
      $display("FAIL halt_cleared: got %b want %b", obs, want);
    end
    tick();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    idle();
    nRST = 1'b0;
    tick();
    nRST = 1'b1;
    ihit = 1'b0;
    tick();
    tick();
    ihit = 1'b1;
    excuDRE = 1'b1; exwsel = 5'd6; idrsel1 = 5'd6;
    tick();
    idle();
    membrnch_eq = 1'b1; memZero = 1'b1;
    tick();
    idle();
    settle();
    vecs++;
    if (stall_cnt !== 4'd3 || flush_cnt !== 4'd1) begin
      miss++;
      $display("FAIL perf_counts: got %0d/%0d want 3/1",
               stall_cnt, flush_cnt);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      nRST        = ($urandom_range(99) >= 2);
      ihit        = ($urandom_range(99) < 75);
      dhit        = ($urandom_range(99) < 35);
      memcuDRE    = ($urandom_range(99) < 30);
      memcuDWE    = ($urandom_range(99) < 10);
      membrnch_eq = ($urandom_range(99) < 10);
      membrnch_ne = ($urandom_range(99) < 10);
      memZero     = 1'($urandom);
      excuDRE     = ($urandom_range(99) < 35);
      exwsel      = REGW'($urandom_range(7));
      idrsel1     = REGW'($urandom_range(7));
      idrsel2     = REGW'($urandom_range(7));
      id_uses_rt  = 1'($urandom);
      idJALflag   = ($urandom_range(99) < 10);
      wbhalt      = ($urandom_range(99) < 2);
      settle();
      want = model();
      vecs++;
      if (obs !== want) begin
        miss++;
        $display("FAIL rand_%0d: got %b want %b", n, obs, want);
      end
`ifdef HAZARD_PERF_EN
      vecs++;
      if (stall_cnt !== CNTW'(mStall)
          || flush_cnt !== CNTW'(mFlush)) begin
        miss++;
        $display("FAIL rand_cnt_%0d: got %0d/%0d want %0d/%0d",
                 n, stall_cnt, flush_cnt,
                 CNTW'(mStall), CNTW'(mFlush));
      end
`endif
      tick();
    end
  endtask

  initial begin
    mHalt = 0;
    mPend = 0;
`ifdef HAZARD_PERF_EN
    mStall = 0;
    mFlush = 0;
`endif
    test_reset();
    test_load_use();
    test_dwait();
    test_branch();
    test_halt();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
